// File: rtl/hack_arb_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter slice.
// Optional burst limiting is enabled with the HACK_ARB_BURST_LIMIT_EN macro.
package hack_arb_pkg;

  localparam int N_SRC  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] onehot8(input logic [SEL_W-1:0] sel);
    onehot8      = '0;
    onehot8[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/hack_mux8_way16.sv
// 8-input, 16-bit datapath mux steered by the arbiter's registered select.
module hack_mux8_way16
  import hack_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/hack_rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 7->0.
module hack_rr_pick8
  import hack_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands at bit 0, encode the lowest set bit, then rotate the index back.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_SRC-1:0];

  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign found = |req;
  assign idx   = ptr + off;

endmodule

// File: rtl/hack_rr_arbiter8_way16.sv
// Round-robin arbiter owning one 16-bit 8:1 mux; registered one-hot grant and select.
// Define HACK_ARB_BURST_LIMIT_EN to force rotation after MAX_BURST cycles of tenure.
module hack_rr_arbiter8_way16
  import hack_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] h,
  output logic [N_SRC-1:0]  gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] out,
  output logic              out_valid
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("hack_rr_arbiter8_way16: MAX_BURST must be within 1..255");
  end

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [N_SRC-1:0] pick_req;
  logic             found;
  logic [SEL_W-1:0] pick;
  logic             rotate;

  // The owner is masked out while granted so a preemption never re-picks it.
  always_comb begin
    pick_req = req;
    if (state == ST_GRANT) pick_req = req & ~onehot8(sel);
  end

`ifdef HACK_ARB_BURST_LIMIT_EN
  logic [7:0] cnt;
  logic       burst_hit;

  assign burst_hit = (cnt == 8'(MAX_BURST)) && (|pick_req);
  assign rotate    = !req[sel] || burst_hit;
`else
  assign rotate    = !req[sel];
`endif

  hack_rr_pick8 u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  // Arbiter FSM: a release or preemption hands over directly to the next owner with no idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
`ifdef HACK_ARB_BURST_LIMIT_EN
      cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt   <= onehot8(pick);
            sel   <= pick;
            ptr   <= pick + 3'd1;
            state <= ST_GRANT;
`ifdef HACK_ARB_BURST_LIMIT_EN
            cnt   <= 8'd1;
`endif
          end
        end
        ST_GRANT: begin
          if (rotate) begin
            if (found) begin
              gnt <= onehot8(pick);
              sel <= pick;
              ptr <= pick + 3'd1;
`ifdef HACK_ARB_BURST_LIMIT_EN
              cnt <= 8'd1;
`endif
            end else begin
              gnt   <= '0;
              state <= ST_IDLE;
            end
          end else begin
`ifdef HACK_ARB_BURST_LIMIT_EN
            if (cnt != 8'(MAX_BURST)) cnt <= cnt + 8'd1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = |gnt;

  hack_mux8_way16 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .sel (sel),
    .out (out)
  );

endmodule
